// File: rtl/fhe_op_scheduler.sv
// Command FIFO + sequencer that hands one FHE operation at a time to the controller.
// Optional watchdog in RUN is enabled by defining SCHED_TIMEOUT_EN.
module fhe_op_scheduler #(
  parameter int ADDR_WIDTH     = 10,
  parameter int FIFO_DEPTH     = 4,
  parameter int PTR_WIDTH      = 2,
  parameter int TAG_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_opcode,
  input  logic [ADDR_WIDTH-1:0] cmd_op1_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_op2_addr,
  input  logic [ADDR_WIDTH-1:0] cmd_out_addr,
  input  logic [TAG_WIDTH-1:0]  cmd_tag,
  output logic                  ctrl_config_en,
  output logic [1:0]            ctrl_opcode,
  output logic [ADDR_WIDTH-1:0] ctrl_op1_base_addr,
  output logic [ADDR_WIDTH-1:0] ctrl_op2_base_addr,
  output logic [ADDR_WIDTH-1:0] ctrl_out_base_addr,
  input  logic                  ctrl_done,
  output logic                  cpl_valid,
  output logic [TAG_WIDTH-1:0]  cpl_tag,
  output logic                  cpl_error,
  output logic                  busy,
  output logic [PTR_WIDTH:0]    queue_count,
  output logic [2:0]            dbg_state
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CONFIG = 3'd1;
  localparam logic [2:0] S_ARM    = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int ENTRY_W = 2 + 3 * ADDR_WIDTH + TAG_WIDTH;
  localparam logic [PTR_WIDTH:0] COUNT_FULL = (PTR_WIDTH + 1)'(FIFO_DEPTH);

  // Handshake: a command is taken on any clk edge where cmd_valid && cmd_ready;
  // cmd_ready depends only on the registered occupancy.
  logic [ENTRY_W-1:0]   mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_WIDTH:0]   count_q;
  logic                 push, pop;

  logic [2:0]            state_q, state_d;
  logic                  cfg_en_q, cfg_en_d;
  logic [1:0]            opcode_q, opcode_d;
  logic [ADDR_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, out_q, out_d;
  logic [TAG_WIDTH-1:0]  cur_tag_q, cur_tag_d;
  logic                  cpl_valid_q, cpl_valid_d;
  logic [TAG_WIDTH-1:0]  cpl_tag_q, cpl_tag_d;

  assign cmd_ready = (count_q != COUNT_FULL);
  assign push      = cmd_valid && cmd_ready;
  assign pop       = (state_q == S_IDLE) && (count_q != '0);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_opcode, cmd_op1_addr, cmd_op2_addr, cmd_out_addr, cmd_tag};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

`ifdef SCHED_TIMEOUT_EN
  logic [9:0] wdog_q, wdog_d;
  logic       cpl_error_q, cpl_error_d;
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  always_comb begin
    state_d     = state_q;
    cfg_en_d    = 1'b0;
    opcode_d    = opcode_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    out_d       = out_q;
    cur_tag_d   = cur_tag_q;
    cpl_valid_d = 1'b0;
    cpl_tag_d   = cpl_tag_q;
`ifdef SCHED_TIMEOUT_EN
    wdog_d      = wdog_q;
    cpl_error_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (pop) begin
          {opcode_d, op1_d, op2_d, out_d, cur_tag_d} = mem_q[rd_ptr_q];
          cfg_en_d = 1'b1;
          state_d  = S_CONFIG;
        end
      end
      S_CONFIG: state_d = S_ARM;
      // The controller drops its stale done on the config edge, so ARM never looks at it.
      S_ARM: begin
        state_d = S_RUN;
`ifdef SCHED_TIMEOUT_EN
        wdog_d  = '0;
`endif
      end
      S_RUN: begin
        if (ctrl_done) begin
          cpl_valid_d = 1'b1;
          cpl_tag_d   = cur_tag_q;
          state_d     = S_DONE;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (wdog_q == 10'(TIMEOUT_CYCLES - 1)) begin
          cpl_valid_d = 1'b1;
          cpl_tag_d   = cur_tag_q;
          cpl_error_d = 1'b1;
          state_d     = S_DONE;
        end else begin
          wdog_d = wdog_q + 10'd1;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cfg_en_q    <= 1'b0;
      opcode_q    <= '0;
      op1_q       <= '0;
      op2_q       <= '0;
      out_q       <= '0;
      cur_tag_q   <= '0;
      cpl_valid_q <= 1'b0;
      cpl_tag_q   <= '0;
`ifdef SCHED_TIMEOUT_EN
      wdog_q      <= '0;
      cpl_error_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cfg_en_q    <= cfg_en_d;
      opcode_q    <= opcode_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      out_q       <= out_d;
      cur_tag_q   <= cur_tag_d;
      cpl_valid_q <= cpl_valid_d;
      cpl_tag_q   <= cpl_tag_d;
`ifdef SCHED_TIMEOUT_EN
      wdog_q      <= wdog_d;
      cpl_error_q <= cpl_error_d;
`endif
    end
  end

`ifdef SCHED_TIMEOUT_EN
  assign cpl_error = cpl_error_q;
`else
  assign cpl_error = 1'b0;
`endif

  assign ctrl_config_en     = cfg_en_q;
  assign ctrl_opcode        = opcode_q;
  assign ctrl_op1_base_addr = op1_q;
  assign ctrl_op2_base_addr = op2_q;
  assign ctrl_out_base_addr = out_q;
  assign cpl_valid          = cpl_valid_q;
  assign cpl_tag            = cpl_tag_q;
  assign busy               = (state_q != S_IDLE);
  assign queue_count        = count_q;
  assign dbg_state          = state_q;

endmodule

// File: tb/tb_fhe_op_scheduler.sv
// Scoreboard bench for fhe_op_scheduler: config and completion queues checked by a monitor.
// The timeout scenario runs only when SCHED_TIMEOUT_EN is defined.
module tb_fhe_op_scheduler;
  localparam int AW = 10;
  localparam int TW = 4;
  localparam int CFG_W = 2 + 3 * AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_opcode = '0;
  logic [AW-1:0] cmd_op1_addr = '0, cmd_op2_addr = '0, cmd_out_addr = '0;
  logic [TW-1:0] cmd_tag = '0;
  logic          ctrl_config_en;
  logic [1:0]    ctrl_opcode;
  logic [AW-1:0] ctrl_op1_base_addr, ctrl_op2_base_addr, ctrl_out_base_addr;
  logic          ctrl_done;
  logic          cpl_valid;
  logic [TW-1:0] cpl_tag;
  logic          cpl_error;
  logic          busy;
  logic [2:0]    queue_count;
  logic [2:0]    dbg_state;

  logic auto_en = 1'b0, auto_done = 1'b0, man_done = 1'b0;
  int   done_delay = 6;
  assign ctrl_done = auto_en ? auto_done : man_done;

  fhe_op_scheduler #(
    .ADDR_WIDTH(AW), .FIFO_DEPTH(4), .PTR_WIDTH(2), .TAG_WIDTH(TW), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_opcode(cmd_opcode),
    .cmd_op1_addr(cmd_op1_addr), .cmd_op2_addr(cmd_op2_addr), .cmd_out_addr(cmd_out_addr),
    .cmd_tag(cmd_tag),
    .ctrl_config_en(ctrl_config_en), .ctrl_opcode(ctrl_opcode),
    .ctrl_op1_base_addr(ctrl_op1_base_addr), .ctrl_op2_base_addr(ctrl_op2_base_addr),
    .ctrl_out_base_addr(ctrl_out_base_addr), .ctrl_done(ctrl_done),
    .cpl_valid(cpl_valid), .cpl_tag(cpl_tag), .cpl_error(cpl_error),
    .busy(busy), .queue_count(queue_count), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0, checks = 0;
  logic [CFG_W-1:0] cfg_q[$];
  logic [TW:0]      exp_q[$];
  int cfg_seen = 0, last_cfg_cycle = 0, last_cpl_cycle = 0;
  logic cfg_prev = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // monitor / scoreboard
  always @(negedge clk) begin
    if (rst_n) begin
      if (ctrl_config_en) begin
        chk("cfg_pulse_single_cycle", 64'(cfg_prev), 64'd0);
        if (!cfg_prev) begin
          cfg_seen++;
          last_cfg_cycle = cyc;
          if (cfg_q.size() == 0) chk("cfg_unexpected", 64'd1, 64'd0);
          else chk("cfg_fields",
                   64'({ctrl_opcode, ctrl_op1_base_addr, ctrl_op2_base_addr, ctrl_out_base_addr}),
                   64'(cfg_q.pop_front()));
        end
      end
      if (cpl_valid) begin
        last_cpl_cycle = cyc;
        if (exp_q.size() == 0) chk("cpl_unexpected", 64'(cpl_tag), 64'hdead);
        else chk("cpl_err_tag", 64'({cpl_error, cpl_tag}), 64'(exp_q.pop_front()));
      end
    end
    cfg_prev = rst_n && ctrl_config_en;
  end

  // controller model: raises done done_delay cycles into RUN
  initial begin
    forever begin
      @(negedge clk);
      if (auto_en && ctrl_config_en) begin
        auto_done = 1'b0;
        repeat (2 + done_delay) @(negedge clk);
        if (auto_en) auto_done = 1'b1;
      end
    end
  end

  // driver
  task automatic push_cmd(input logic [1:0] op, input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                          input logic [AW-1:0] a3, input logic [TW-1:0] tag, input logic err,
                          output int acc_cyc);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_opcode = op; cmd_op1_addr = a1; cmd_op2_addr = a2;
    cmd_out_addr = a3; cmd_tag = tag;
    while (!cmd_ready && n < 300) begin @(negedge clk); n++; end
    if (!cmd_ready) chk("push_ready_timeout", 64'd0, 64'd1);
    else begin
      cfg_q.push_back({op, a1, a2, a3});
      exp_q.push_back({err, tag});
    end
    @(posedge clk); #1;
    acc_cyc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 600) begin @(negedge clk); #1; n++; end
    chk(name, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_cfg(input int target, input string name);
    int n = 0;
    while (cfg_seen < target && n < 300) begin @(negedge clk); #1; n++; end
    chk(name, 64'(cfg_seen), 64'(target));
  endtask

  initial begin
    int acc, base, c1, c2, n;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_count", 64'(queue_count), 64'd0);
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_outs", 64'({ctrl_config_en, cpl_valid, cpl_error, cpl_tag, ctrl_opcode}), 64'd0);
    chk("rst_addrs", 64'({ctrl_op1_base_addr, ctrl_op2_base_addr, ctrl_out_base_addr}), 64'd0);
    rst_n = 1'b1;

    // single command, done 6 cycles into RUN
    auto_en = 1'b1; done_delay = 6;
    push_cmd(2'd2, 10'h010, 10'h020, 10'h030, 4'd5, 1'b0, acc);
    drain("single_drain");
    chk("single_cfg_latency", 64'(last_cfg_cycle), 64'(acc + 1));
    chk("single_cpl_latency", 64'(last_cpl_cycle), 64'(last_cfg_cycle + 9));

    // five back-to-back pushes; tag 1 lands on the same edge as the pop of tag 0
    done_delay = 10;
    push_cmd(2'd0, 10'h100, 10'h101, 10'h102, 4'd0, 1'b0, acc);
    push_cmd(2'd1, 10'h110, 10'h111, 10'h112, 4'd1, 1'b0, acc);
    chk("push_pop_same_edge_count", 64'(queue_count), 64'd1);
    push_cmd(2'd3, 10'h120, 10'h121, 10'h122, 4'd2, 1'b0, acc);
    push_cmd(2'd2, 10'h130, 10'h131, 10'h132, 4'd3, 1'b0, acc);
    push_cmd(2'd1, 10'h3ff, 10'h000, 10'h2aa, 4'd4, 1'b0, acc);
    chk("full_count", 64'(queue_count), 64'd4);
    chk("full_ready_low", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    cmd_valid = 1'b1; cmd_tag = 4'd9;
    repeat (2) @(negedge clk);
    cmd_valid = 1'b0;
    chk("push_while_full_ignored", 64'(queue_count), 64'd4);
    drain("b2b_drain");

    // stale done held through config must not complete before RUN
    auto_en = 1'b0; man_done = 1'b1;
    push_cmd(2'd3, 10'h055, 10'h0aa, 10'h0ff, 4'd6, 1'b0, acc);
    drain("stale_drain");
    chk("stale_cpl_after_arm", 64'(last_cpl_cycle), 64'(last_cfg_cycle + 3));
    man_done = 1'b0;

    // reset mid-RUN with two commands queued
    auto_en = 1'b1; done_delay = 30;
    base = cfg_seen;
    push_cmd(2'd1, 10'h001, 10'h002, 10'h003, 4'd10, 1'b0, acc);
    push_cmd(2'd2, 10'h004, 10'h005, 10'h006, 4'd11, 1'b0, acc);
    push_cmd(2'd3, 10'h007, 10'h008, 10'h009, 4'd12, 1'b0, acc);
    n = 0;
    while (dbg_state != 3'd3 && n < 50) begin @(negedge clk); #1; n++; end
    chk("reached_run", 64'(dbg_state), 64'd3);
    chk("queued_before_reset", 64'(queue_count), 64'd2);
    @(negedge clk);
    rst_n = 1'b0; auto_en = 1'b0;
    cfg_q.delete(); exp_q.delete();
    @(negedge clk);
    chk("midrun_rst_busy", 64'(busy), 64'd0);
    chk("midrun_rst_count", 64'(queue_count), 64'd0);
    chk("midrun_rst_cpl", 64'(cpl_valid), 64'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_cfg_after_reset", 64'(cfg_seen), 64'(base + 1));
    chk("idle_after_reset", 64'(busy), 64'd0);

`ifdef SCHED_TIMEOUT_EN
    // watchdog: tag 7 times out after 8 RUN cycles, tag 8 gets done on its last RUN cycle
    man_done = 1'b0;
    base = cfg_seen;
    push_cmd(2'd0, 10'h011, 10'h022, 10'h033, 4'd7, 1'b1, acc);
    push_cmd(2'd1, 10'h044, 10'h055, 10'h066, 4'd8, 1'b0, acc);
    wait_cfg(base + 1, "to_first_cfg");
    c1 = last_cfg_cycle;
    wait_cfg(base + 2, "to_second_cfg");
    c2 = last_cfg_cycle;
    chk("to_cpl_cycle", 64'(last_cpl_cycle), 64'(c1 + 10));
    chk("to_next_cfg_cycle", 64'(c2), 64'(c1 + 12));
    repeat (9) @(negedge clk);
    man_done = 1'b1;
    drain("to_drain");
    chk("done_beats_timeout_cycle", 64'(last_cpl_cycle), 64'(c2 + 10));
    man_done = 1'b0;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
